audio_decim_frontend: RTL and testbench

- Parametrised successor to the mic front end: DC-offset calibration, saturating offset removal, then a boxcar-averaging decimator with power-of-two factor.
- Sits between the mic deserialiser (one-cycle valid strobes at 48 kHz) and downstream DSP.
- Adds run-time recalibration, saturation and a configurable decimation ratio.
- Optionally tracks slow DC drift after calibration.

---
 rtl/audio_fe_pkg.sv | 38 +++
 rtl/boxcar_decimator.sv | 50 +++++
 rtl/audio_decim_frontend.sv | 149 ++++++++++++++
 tb/tb_audio_decim_frontend.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fe_pkg.sv
// Shared types and helpers for the audio decimating front end:
// FSM state encoding and a generic signed saturation function.
package audio_fe_pkg;

  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] sat_word_t;

  typedef enum logic {
    FE_CAL = 1'b0,
    FE_RUN = 1'b1
  } fe_state_t;

  typedef struct packed {
    sat_word_t value;
    logic      clip;
  } sat_result_t;

  // Clips a signed value into the two's-complement range of 'width' bits.
  function automatic sat_result_t sat_signed(input sat_word_t value, input int width);
    sat_result_t res;
    sat_word_t   max_v;
    sat_word_t   min_v;
    max_v = (sat_word_t'(1) <<< (width - 1)) - sat_word_t'(1);
    min_v = -max_v - sat_word_t'(1);
    res.clip = 1'b1;
    if (value > max_v) begin
      res.value = max_v;
    end else if (value < min_v) begin
      res.value = min_v;
    end else begin
      res.value = value;
      res.clip  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/boxcar_decimator.sv
// Boxcar-averaging decimator: sums 2^DECIM_LOG2 valid samples and emits
// their floor-average one cycle after the group-completing input.
module boxcar_decimator #(
  parameter int WIDTH      = 16,
  parameter int DECIM_LOG2 = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_data
);

  localparam int ACC_W = WIDTH + DECIM_LOG2;
  localparam int PH_W  = DECIM_LOG2 + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;
  logic [PH_W-1:0]         r_phase;
  logic                    w_last;

  assign w_sum  = r_acc + ACC_W'(i_data);
  assign w_last = (r_phase == PH_LAST);

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_phase <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid) begin
        if (w_last) begin
          o_data  <= WIDTH'(w_sum >>> DECIM_LOG2);
          o_valid <= 1'b1;
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/audio_decim_frontend.sv
// Mic front end: DC-offset calibration, saturating offset removal, boxcar decimation.
// Define AUDIO_FE_DC_TRACK_EN to let the offset follow slow DC drift while running.
module audio_decim_frontend
  import audio_fe_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CAL_LOG2    = 10,
  parameter int DECIM_LOG2  = 1,
  parameter int TRACK_SHIFT = 12
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    recal_in,
  input  logic                    sample_valid_in,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    sample_valid_out,
  output logic signed [WIDTH-1:0] offset_out,
  output logic                    calibrated_out,
  output logic                    sat_out
);

  localparam int CAL_W     = WIDTH + CAL_LOG2;
  localparam int CAL_CNT_W = CAL_LOG2 + 1;
  localparam logic [CAL_CNT_W-1:0] CAL_LAST = CAL_CNT_W'((1 << CAL_LOG2) - 1);

  fe_state_t               r_state;
  fe_state_t               w_state_next;
  logic signed [CAL_W-1:0] r_cal_acc;
  logic signed [CAL_W-1:0] w_cal_sum;
  logic [CAL_CNT_W-1:0]    r_cal_cnt;
  logic signed [WIDTH-1:0] r_offset;
  logic signed [WIDTH-1:0] w_cal_offset;
  logic                    r_sat;
  logic                    w_cal_accept;
  logic                    w_cal_done;
  logic                    w_run_update;
  logic signed [WIDTH:0]   w_diff_raw;
  logic signed [WIDTH-1:0] w_diff_sat;
  logic                    w_clip;
  sat_result_t             w_sat_res;

  // Correction path: one extra bit so the subtraction itself never wraps.
  assign w_diff_raw = {sample_in[WIDTH-1], sample_in} - {r_offset[WIDTH-1], r_offset};
  assign w_sat_res  = sat_signed(SAT_W'(w_diff_raw), WIDTH);
  assign w_diff_sat = w_sat_res.value[WIDTH-1:0];
  // Any result that is not a pure sign extension of WIDTH bits also counts as a clip.
  assign w_clip     = w_sat_res.clip |
                      (w_sat_res.value[SAT_W-1:WIDTH] != {(SAT_W-WIDTH){w_sat_res.value[WIDTH-1]}});

  // A recal pulse wins over a coincident valid for calibration purposes.
  assign w_cal_accept = (r_state == FE_CAL) && sample_valid_in && !recal_in;
  assign w_cal_done   = w_cal_accept && (r_cal_cnt == CAL_LAST);
  assign w_run_update = (r_state == FE_RUN) && sample_valid_in && !recal_in;
  assign w_cal_sum    = r_cal_acc + CAL_W'(sample_in);
  assign w_cal_offset = WIDTH'(w_cal_sum >>> CAL_LOG2);

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state <= FE_CAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: default first so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    if (recal_in) begin
      w_state_next = FE_CAL;
    end else if (w_cal_done) begin
      w_state_next = FE_RUN;
    end
  end

  always_comb begin
    calibrated_out = (r_state == FE_RUN);
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_cal_acc <= '0;
      r_cal_cnt <= '0;
    end else if (recal_in || w_cal_done) begin
      r_cal_acc <= '0;
      r_cal_cnt <= '0;
    end else if (w_cal_accept) begin
      r_cal_acc <= w_cal_sum;
      r_cal_cnt <= r_cal_cnt + 1'b1;
    end
  end

`ifdef AUDIO_FE_DC_TRACK_EN
  localparam int TRK_W = WIDTH + TRACK_SHIFT;

  logic signed [TRK_W-1:0] r_trk;
  logic signed [TRK_W-1:0] w_trk_sum;

  assign w_trk_sum = r_trk + TRK_W'(w_diff_raw);

  // The leaky estimate takes effect from the next sample onward.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_trk    <= '0;
      r_offset <= '0;
    end else if (w_cal_done) begin
      r_trk    <= TRK_W'(w_cal_offset) <<< TRACK_SHIFT;
      r_offset <= w_cal_offset;
    end else if (w_run_update) begin
      r_trk    <= w_trk_sum;
      r_offset <= WIDTH'(w_trk_sum >>> TRACK_SHIFT);
    end
  end
`else
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_offset <= '0;
    end else if (w_cal_done) begin
      r_offset <= w_cal_offset;
    end
  end
`endif

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_sat <= 1'b0;
    end else if (recal_in) begin
      r_sat <= 1'b0;
    end else if (sample_valid_in && w_clip) begin
      r_sat <= 1'b1;
    end
  end

  assign offset_out = r_offset;
  assign sat_out    = r_sat;

  boxcar_decimator #(
    .WIDTH      (WIDTH),
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_decim (
    .i_clk   (audio_clk),
    .i_rst   (rst_in),
    .i_valid (sample_valid_in),
    .i_data  (w_diff_sat),
    .o_valid (sample_valid_out),
    .o_data  (sample_out)
  );

endmodule

// File: tb/tb_audio_decim_frontend.sv
// Self-checking bench: two front ends (decimate by 1 and by 4) share one stimulus
// stream and are compared against an arithmetic reference model.
module tb_audio_decim_frontend;

  localparam int W  = 16;
  localparam int CL = 4;
  localparam int TS = 4;
  localparam int CAL_N = 1 << CL;
  localparam int DEC1_N = 4;

  logic audio_clk = 1'b0;
  logic rst_in;
  logic recal_in;
  logic sample_valid_in;
  logic signed [W-1:0] sample_in;

  logic signed [W-1:0] out0, off0, out1, off1;
  logic vout0, cal0, sat0, vout1, cal1, sat1;

  always #5 audio_clk = ~audio_clk;

  audio_decim_frontend #(.WIDTH(W), .CAL_LOG2(CL), .DECIM_LOG2(0), .TRACK_SHIFT(TS)) dut0 (
    .audio_clk(audio_clk), .rst_in(rst_in), .recal_in(recal_in),
    .sample_valid_in(sample_valid_in), .sample_in(sample_in),
    .sample_out(out0), .sample_valid_out(vout0), .offset_out(off0),
    .calibrated_out(cal0), .sat_out(sat0));

  audio_decim_frontend #(.WIDTH(W), .CAL_LOG2(CL), .DECIM_LOG2(2), .TRACK_SHIFT(TS)) dut1 (
    .audio_clk(audio_clk), .rst_in(rst_in), .recal_in(recal_in),
    .sample_valid_in(sample_valid_in), .sample_in(sample_in),
    .sample_out(out1), .sample_valid_out(vout1), .offset_out(off1),
    .calibrated_out(cal1), .sat_out(sat1));

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_offset;
  bit     m_cal;
  bit     m_sat;
  int     m_cal_q[$];
  int     m_grp0[$];
  int     m_grp1[$];
  int     m_out0, m_out1;
  bit     m_v0, m_v1;
  longint m_trk;

  function automatic int floor_div(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return int'(q);
  endfunction

  function automatic int clamp(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_offset = 0; m_cal = 0; m_sat = 0; m_trk = 0;
    m_cal_q.delete(); m_grp0.delete(); m_grp1.delete();
    m_out0 = 0; m_out1 = 0; m_v0 = 0; m_v1 = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit rc);
    int raw, sv;
    raw = s - m_offset;
    sv  = clamp(raw);
    m_v0 = 0; m_v1 = 0;
    if (v) begin
      m_grp0.push_back(sv);
      if (m_grp0.size() == 1) begin
        m_out0 = floor_div(m_grp0.sum(), 1); m_v0 = 1; m_grp0.delete();
      end
      m_grp1.push_back(sv);
      if (m_grp1.size() == DEC1_N) begin
        m_out1 = floor_div(m_grp1.sum(), DEC1_N); m_v1 = 1; m_grp1.delete();
      end
    end
    if (rc) begin
      m_cal = 0; m_sat = 0; m_cal_q.delete();
    end else if (v) begin
      if (sv != raw) m_sat = 1;
      if (!m_cal) begin
        m_cal_q.push_back(s);
        if (m_cal_q.size() == CAL_N) begin
          m_offset = floor_div(m_cal_q.sum(), CAL_N);
          m_cal = 1;
          m_trk = longint'(m_offset) * (1 << TS);
          m_cal_q.delete();
        end
      end
`ifdef AUDIO_FE_DC_TRACK_EN
      else begin
        m_trk = m_trk + raw;
        m_offset = floor_div(m_trk, 1 << TS);
      end
`endif
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, sample 1 after.
  task automatic step(input bit v, input int s, input bit rc);
    @(negedge audio_clk);
    sample_valid_in = v;
    sample_in = W'(s);
    recal_in = rc;
    @(posedge audio_clk);
    model_step(v, s, rc);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; recal_in = 1'b0; sample_valid_in = 1'b0; sample_in = '0;
    model_reset();
    repeat (2) @(posedge audio_clk);
    #1;
    checks++; if (out0 !== 16'sd0) begin errors++; $display("FAIL reset_out0: got %0d expected 0", out0); end
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL reset_vout0: got %b expected 0", vout0); end
    checks++; if (off0 !== 16'sd0) begin errors++; $display("FAIL reset_off0: got %0d expected 0", off0); end
    checks++; if (cal0 !== 1'b0) begin errors++; $display("FAIL reset_cal0: got %b expected 0", cal0); end
    checks++; if (sat0 !== 1'b0) begin errors++; $display("FAIL reset_sat0: got %b expected 0", sat0); end
    checks++; if (vout1 !== 1'b0) begin errors++; $display("FAIL reset_vout1: got %b expected 0", vout1); end
    @(negedge audio_clk);
    rst_in = 1'b0;
  endtask

  task automatic test_calibrate_100();
    for (int i = 0; i < CAL_N - 1; i++) begin
      step(1, 100, 0);
      checks++; if (vout0 !== 1'b1 || out0 !== 16'sd100) begin
        errors++; $display("FAIL precal_pass: got %0d/%b expected 100/1", out0, vout0); end
    end
    checks++; if (cal0 !== 1'b0) begin errors++; $display("FAIL cal100_early: got %b expected 0", cal0); end
    step(1, 100, 0);
    checks++; if (off0 !== 16'sd100) begin errors++; $display("FAIL cal100_offset: got %0d expected 100", off0); end
    checks++; if (cal0 !== 1'b1) begin errors++; $display("FAIL cal100_done: got %b expected 1", cal0); end
    step(1, 130, 0);
    checks++; if (vout0 !== 1'b1 || out0 !== 16'sd30) begin
      errors++; $display("FAIL corr_130: got %0d/%b expected 30/1", out0, vout0); end
    step(0, 0, 0);
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL vout_pulse: got %b expected 0", vout0); end
  endtask

  task automatic test_cal_negative();
    step(0, 0, 1);
    checks++; if (cal0 !== 1'b0) begin errors++; $display("FAIL recal_clears_cal: got %b expected 0", cal0); end
    for (int i = 0; i < CAL_N; i++) step(1, -3, 0);
    checks++; if (off0 !== -16'sd3 || cal0 !== 1'b1) begin
      errors++; $display("FAIL cal_minus3: got %0d/%b expected -3/1", off0, cal0); end
    step(0, 0, 1);
    for (int i = 0; i < CAL_N; i++) step(1, (i < CAL_N / 2) ? -1 : -2, 0);
    checks++; if (off0 !== -16'sd2) begin errors++; $display("FAIL cal_floor: got %0d expected -2", off0); end
    checks++; if (off0 !== W'(m_offset)) begin errors++; $display("FAIL cal_floor_model: got %0d expected %0d", off0, m_offset); end
  endtask

  task automatic test_saturation();
    step(0, 0, 1);
    for (int i = 0; i < CAL_N; i++) step(1, -1000, 0);
    checks++; if (off0 !== -16'sd1000) begin errors++; $display("FAIL cal_m1000: got %0d expected -1000", off0); end
    step(1, 31767, 0);
    checks++; if (out0 !== 16'sd32767 || sat0 !== 1'b0) begin
      errors++; $display("FAIL edge_noclip: got %0d/%b expected 32767/0", out0, sat0); end
    step(1, 32000, 0);
    checks++; if (out0 !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", out0); end
    checks++; if (sat0 !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b expected 1", sat0); end
    step(0, 0, 1);
    checks++; if (sat0 !== 1'b0 || cal0 !== 1'b0) begin
      errors++; $display("FAIL recal_clear: got sat=%b cal=%b expected 0/0", sat0, cal0); end
    checks++; if (off0 !== W'(m_offset)) begin errors++; $display("FAIL recal_keeps_off: got %0d expected %0d", off0, m_offset); end
`ifndef AUDIO_FE_DC_TRACK_EN
    checks++; if (off0 !== -16'sd1000) begin errors++; $display("FAIL recal_keeps_m1000: got %0d expected -1000", off0); end
`endif
    for (int i = 0; i < CAL_N; i++) step(1, 1000, 0);
    step(1, -32000, 0);
    checks++; if (out0 !== -16'sd32768 || sat0 !== 1'b1) begin
      errors++; $display("FAIL sat_neg: got %0d/%b expected -32768/1", out0, sat0); end
  endtask

  task automatic test_back_to_back();
    int seq[8] = '{4, 8, 12, 16, 1, 1, 1, 1};
    int vals[$];
    step(0, 0, 1);
    for (int i = 0; i < CAL_N; i++) step(1, 0, 0);
    for (int i = 0; i < DEC1_N && m_grp1.size() != 0; i++) step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0);
      checks++; if (vout1 !== m_v1 || (m_v1 && out1 !== W'(m_out1))) begin
        errors++; $display("FAIL b2b_model[%0d]: got %0d/%b expected %0d/%b", i, out1, vout1, m_out1, m_v1); end
      if (vout1 === 1'b1) vals.push_back(int'(out1));
    end
    step(0, 0, 0);
    checks++; if (vals.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", vals.size()); end
`ifndef AUDIO_FE_DC_TRACK_EN
    else begin
      checks++; if (vals[0] != 10 || vals[1] != 1) begin
        errors++; $display("FAIL b2b_values: got %0d,%0d expected 10,1", vals[0], vals[1]); end
    end
`endif
  endtask

  task automatic test_recal_coincident();
    step(1, 50, 1);
    checks++; if (vout0 !== 1'b1 || out0 !== W'(m_out0)) begin
      errors++; $display("FAIL recal_flow: got %0d/%b expected %0d/1", out0, vout0, m_out0); end
    for (int i = 0; i < CAL_N - 1; i++) begin
      step(1, 7, 0);
      checks++; if (vout1 !== m_v1) begin errors++; $display("FAIL recal_cadence[%0d]: got %b expected %b", i, vout1, m_v1); end
    end
    checks++; if (cal0 !== 1'b0) begin errors++; $display("FAIL recal_needs16: got %b expected 0", cal0); end
    step(1, 7, 0);
    checks++; if (cal0 !== 1'b1 || off0 !== 16'sd7) begin
      errors++; $display("FAIL recal_cal7: got %b/%0d expected 1/7", cal0, off0); end
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 900, 0);
    step(0, 0, 1);
    for (int i = 0; i < CAL_N - 1; i++) step(1, 11, 0);
    checks++; if (cal0 !== 1'b0) begin errors++; $display("FAIL restart_early: got %b expected 0", cal0); end
    step(1, 11, 0);
    checks++; if (cal0 !== 1'b1 || off0 !== 16'sd11) begin
      errors++; $display("FAIL restart_cal11: got %b/%0d expected 1/11", cal0, off0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      bit v, rc;
      int s;
      v  = ($urandom_range(9) < 7);
      rc = ($urandom_range(99) == 0);
      s  = int'($urandom_range(32767)) - 16384;
      step(v, s, rc);
      checks++; if (vout0 !== m_v0 || out0 !== W'(m_out0)) begin
        errors++; $display("FAIL rnd_out0[%0d]: got %0d/%b expected %0d/%b", n, out0, vout0, m_out0, m_v0); end
      checks++; if (vout1 !== m_v1 || out1 !== W'(m_out1)) begin
        errors++; $display("FAIL rnd_out1[%0d]: got %0d/%b expected %0d/%b", n, out1, vout1, m_out1, m_v1); end
      checks++; if (off0 !== W'(m_offset) || off1 !== W'(m_offset)) begin
        errors++; $display("FAIL rnd_offset[%0d]: got %0d/%0d expected %0d", n, off0, off1, m_offset); end
      checks++; if (cal0 !== m_cal || cal1 !== m_cal || sat0 !== m_sat || sat1 !== m_sat) begin
        errors++; $display("FAIL rnd_flags[%0d]: got cal=%b sat=%b expected cal=%b sat=%b", n, cal0, sat0, m_cal, m_sat); end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1);
    for (int i = 0; i < CAL_N; i++) step(1, 500, 0);
    for (int i = 0; i < DEC1_N && m_grp1.size() != 2; i++) step(1, 3, 0);
    @(negedge audio_clk);
    #2 rst_in = 1'b1;
    sample_valid_in = 1'b0;
    #1;
    checks++; if (out0 !== 16'sd0 || out1 !== 16'sd0) begin
      errors++; $display("FAIL async_rst_out: got %0d/%0d expected 0/0", out0, out1); end
    checks++; if (off0 !== 16'sd0 || off1 !== 16'sd0) begin
      errors++; $display("FAIL async_rst_off: got %0d/%0d expected 0/0", off0, off1); end
    checks++; if (cal0 !== 1'b0 || sat0 !== 1'b0 || vout0 !== 1'b0 || vout1 !== 1'b0) begin
      errors++; $display("FAIL async_rst_flags: got cal=%b sat=%b v=%b%b expected 0", cal0, sat0, vout0, vout1); end
    model_reset();
    @(posedge audio_clk);
    @(negedge audio_clk);
    rst_in = 1'b0;
    for (int i = 0; i < DEC1_N; i++) begin
      step(1, 8, 0);
      checks++; if (vout1 !== ((i == DEC1_N - 1) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL post_rst_phase[%0d]: got %b expected %b", i, vout1, (i == DEC1_N - 1)); end
    end
    checks++; if (out1 !== 16'sd8) begin errors++; $display("FAIL post_rst_value: got %0d expected 8", out1); end
  endtask

`ifdef AUDIO_FE_DC_TRACK_EN
  task automatic test_dc_track();
    int prev;
    step(0, 0, 1);
    for (int i = 0; i < CAL_N; i++) step(1, 0, 0);
    checks++; if (off0 !== 16'sd0) begin errors++; $display("FAIL track_start: got %0d expected 0", off0); end
    prev = 0;
    for (int i = 0; i < 250; i++) begin
      step(1, 160, 0);
      checks++; if (int'(off0) < prev || off0 !== W'(m_offset)) begin
        errors++; $display("FAIL track_step[%0d]: got %0d expected %0d (prev %0d)", i, off0, m_offset, prev); end
      prev = int'(off0);
    end
    checks++; if (160 - int'(off0) > 2 || int'(off0) > 160) begin
      errors++; $display("FAIL track_converge: got %0d expected 158..160", off0); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_calibrate_100();
    test_cal_negative();
    test_saturation();
    test_back_to_back();
    test_recal_coincident();
    test_random();
    test_reset_mid();
`ifdef AUDIO_FE_DC_TRACK_EN
    test_dc_track();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
